// File: rtl/instruction_prefetch_unit_pkg.sv
// Shared types for the instruction prefetch unit: queue entry layout and request FSM states.
package instruction_prefetch_unit_pkg;

  typedef logic [31:0] uint32_t;

  typedef struct packed {
    uint32_t pc;
    uint32_t insn;
  } prefetch_entry_t;

  localparam int unsigned FETCH_STEP = 4;

  typedef enum logic {
    REQ_IDLE,
    REQ_WAIT
  } prefetch_req_state_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous show-ahead FIFO of prefetched {pc, insn} entries; clear beats push/pop.
module prefetch_fifo
  import instruction_prefetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  prefetch_entry_t     push_data,
  input  logic                pop,
  input  logic                clear,
  output prefetch_entry_t     head_c,
  output logic [DEPTH_LOG2:0] count
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  prefetch_entry_t mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((32'(count) < DEPTH) || do_pop);
  assign head_c  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only observed through count.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetcher: issues in-order Avalon-MM reads ahead of the decoder and queues
// the returned words with their fetch address; redirect flushes and drops in-flight data.
module instruction_prefetch_unit
  import instruction_prefetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  input  logic                consume,
  output logic                ir_valid,
  output logic [31:0]         ir,
  output logic [31:0]         ir_pc,
  output logic [DEPTH_LOG2:0] occupancy,
  output logic [31:0]         avm_address,
  output logic                avm_read,
  input  logic                avm_waitrequest,
  input  logic                avm_readdatavalid,
  input  logic [31:0]         avm_readdata
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  prefetch_req_state_t state, state_next;
  logic [31:0]         fetch_pc, fetch_pc_next, addr_next;
  logic [OW-1:0]       outstanding, outstanding_next;
  logic [OW-1:0]       drop_cnt, drop_next;
  logic                stale, stale_next;
  logic                accept, push, pop, may_issue;
  int unsigned         occ_after, out_after;
  logic [31:0]         tag_mem [MAX_OUTSTANDING];
  logic [TW-1:0]       tag_wr, tag_rd;
  prefetch_entry_t     head_c, push_data;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + TW'(1);
  endfunction

  assign accept    = avm_read && !avm_waitrequest;
  assign push      = avm_readdatavalid && (drop_cnt == '0) && !redirect;
  assign pop       = consume && ir_valid && !redirect;
  assign push_data = '{pc: tag_mem[tag_rd], insn: avm_readdata};

  prefetch_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .clear    (redirect),
    .head_c   (head_c),
    .count    (occupancy)
  );

  assign ir_valid = (occupancy != '0);
  assign ir       = ir_valid ? head_c.insn : 32'h0;
  assign ir_pc    = ir_valid ? head_c.pc   : 32'h0;

  // Request addresses in flight, popped in order as responses return.
  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wr] <= avm_address;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_wr <= '0;
      tag_rd <= '0;
    end else begin
      if (accept)            tag_wr <= tag_inc(tag_wr);
      if (avm_readdatavalid) tag_rd <= tag_inc(tag_rd);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= REQ_IDLE;
      avm_read    <= 1'b0;
      avm_address <= RESET_PC;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      stale       <= 1'b0;
    end else begin
      state       <= state_next;
      avm_read    <= (state_next == REQ_WAIT);
      avm_address <= addr_next;
      fetch_pc    <= fetch_pc_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_next;
      stale       <= stale_next;
    end
  end

  // Credit check uses post-edge occupancy/outstanding; a request held across a redirect
  // is marked stale so its response is dropped and fetch_pc is not advanced by it.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    addr_next     = avm_address;
    drop_next     = drop_cnt;
    stale_next    = stale;

    occ_after        = redirect ? 32'd0 : 32'(occupancy) + 32'(push) - 32'(pop);
    out_after        = 32'(outstanding) + 32'(accept) - 32'(avm_readdatavalid);
    outstanding_next = OW'(out_after);
    may_issue        = !redirect && ((occ_after + out_after) < DEPTH)
                       && (out_after < MAX_OUTSTANDING);

    if (accept) begin
      stale_next = 1'b0;
      if (!stale) fetch_pc_next = fetch_pc + FETCH_STEP;
    end

    if (redirect) begin
      fetch_pc_next = redirect_pc & 32'hFFFF_FFFC;
      drop_next     = OW'(out_after);
      stale_next    = (state == REQ_WAIT) && !accept;
    end else begin
      if (avm_readdatavalid && (drop_cnt != '0)) drop_next = drop_cnt - OW'(1);
      if (accept && stale)                       drop_next = drop_next + OW'(1);
    end

    case (state)
      REQ_IDLE: begin
        if (may_issue) begin
          state_next = REQ_WAIT;
          addr_next  = fetch_pc_next;
        end
      end
      REQ_WAIT: begin
        if (accept) begin
          if (may_issue) addr_next  = fetch_pc_next;
          else           state_next = REQ_IDLE;
        end
      end
      default: state_next = REQ_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Directed bench for instruction_prefetch_unit with an in-order Avalon-MM read agent model.
module tb_instruction_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        consume = 1'b0;
  logic        ir_valid;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic [2:0]  occupancy;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic        avm_readdatavalid;
  logic [31:0] avm_readdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instruction_prefetch_unit #(
    .DEPTH_LOG2     (2),
    .MAX_OUTSTANDING(2),
    .RESET_PC       (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .consume          (consume),
    .ir_valid         (ir_valid),
    .ir               (ir),
    .ir_pc            (ir_pc),
    .occupancy        (occupancy),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata     (avm_readdata)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Agent: responds in order, lat cycles after the accepting edge (lat=1 -> next cycle).
  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t q[$];
  int   cyc = 0;
  int   lat = 1;
  int   acc10 = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      cyc = 0;
      acc10 = 0;
      avm_readdatavalid <= 1'b0;
      avm_readdata      <= 32'h0;
    end else begin
      cyc = cyc + 1;
      if (avm_read && !avm_waitrequest) begin
        q.push_back('{avm_address, cyc + lat - 1});
        if (avm_address == 32'h10) acc10 = acc10 + 1;
      end
      if (q.size() != 0 && q[0].due <= cyc) begin
        avm_readdatavalid <= 1'b1;
        avm_readdata      <= mem_word(q[0].addr);
        void'(q.pop_front());
      end else begin
        avm_readdatavalid <= 1'b0;
        avm_readdata      <= 32'h0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic do_reset(input int latency);
    rst = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    consume = 1'b0;
    avm_waitrequest = 1'b0;
    lat = latency;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Checks the next n popped entries form a consecutive stream starting at first_pc.
  task automatic expect_stream(input string tag, input logic [31:0] first_pc, input int n);
    logic [31:0] pc;
    int got;
    int guard;
    pc = first_pc;
    got = 0;
    guard = 0;
    while (got < n && guard < 200) begin
      if (ir_valid && consume) begin
        check_eq({tag, "_pc"}, ir_pc, pc);
        check_eq({tag, "_ir"}, ir, mem_word(pc));
        pc = pc + 32'd4;
        got++;
      end
      if (got < n) begin
        @(negedge clk);
        guard++;
      end
    end
    if (got < n) check_eq({tag, "_count"}, 32'(got), 32'(n));
  endtask

  task automatic wait_addr(input string tag, input logic [31:0] a);
    int g;
    g = 0;
    while (!(avm_read && avm_address == a) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check_eq({tag, "_reach"}, avm_address, a);
  endtask

  initial begin
    int max_occ;
    int g;

    // Reset state
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ir_valid", 32'(ir_valid), 32'd0);
    check_eq("rst_avm_read", 32'(avm_read), 32'd0);
    check_eq("rst_avm_addr", avm_address, 32'h0);
    check_eq("rst_occ", 32'(occupancy), 32'd0);
    check_eq("rst_ir", ir, 32'h0);
    check_eq("rst_ir_pc", ir_pc, 32'h0);

    // 1: streaming with consume held, 3-cycle first latency, no gaps
    do_reset(1);
    consume = 1'b1;
    @(negedge clk);
    check_eq("t1_read", 32'(avm_read), 32'd1);
    check_eq("t1_addr0", avm_address, 32'h0);
    @(negedge clk);
    check_eq("t1_valid_c2", 32'(ir_valid), 32'd0);
    @(negedge clk);
    check_eq("t1_valid_c3", 32'(ir_valid), 32'd1);
    check_eq("t1_pc0", ir_pc, 32'h0);
    check_eq("t1_ir0", ir, mem_word(32'h0));
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check_eq("t1_valid", 32'(ir_valid), 32'd1);
      check_eq("t1_pc", ir_pc, 32'(4 * i));
      check_eq("t1_ir", ir, mem_word(32'(4 * i)));
    end

    // 2: backpressure fills the queue, then drains 8 words in order
    do_reset(1);
    max_occ = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (32'(occupancy) > 32'(max_occ)) max_occ = 32'(occupancy);
    end
    check_eq("t2_occ", 32'(occupancy), 32'd4);
    check_eq("t2_max_occ", 32'(max_occ), 32'd4);
    check_eq("t2_read_low", 32'(avm_read), 32'd0);
    check_eq("t2_head", ir_pc, 32'h0);
    consume = 1'b1;
    expect_stream("t2", 32'h0, 8);

    // 3: waitrequest stall holds address 0x10 for 5 cycles, single accept
    do_reset(1);
    consume = 1'b1;
    wait_addr("t3", 32'h10);
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_hold_read", 32'(avm_read), 32'd1);
      check_eq("t3_hold_addr", avm_address, 32'h10);
      @(negedge clk);
    end
    avm_waitrequest = 1'b0;
    check_eq("t3_still_addr", avm_address, 32'h10);
    @(negedge clk);
    check_eq("t3_next_addr", avm_address, 32'h14);
    repeat (4) @(negedge clk);
    check_eq("t3_accepts", 32'(acc10), 32'd1);

    // 4: redirect with two reads in flight; both responses dropped
    do_reset(3);
    consume = 1'b1;
    g = 0;
    while (q.size() != 2 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check_eq("t4_inflight", 32'(q.size()), 32'd2);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0203;
    @(negedge clk);
    redirect = 1'b0;
    check_eq("t4_valid_after", 32'(ir_valid), 32'd0);
    expect_stream("t4", 32'h200, 3);

    // 5: redirect while held at 0x40; held read completes and is discarded
    do_reset(1);
    consume = 1'b1;
    wait_addr("t5", 32'h40);
    avm_waitrequest = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0100;
    @(negedge clk);
    redirect = 1'b0;
    check_eq("t5_valid_after", 32'(ir_valid), 32'd0);
    check_eq("t5_hold_addr", avm_address, 32'h40);
    check_eq("t5_hold_read", 32'(avm_read), 32'd1);
    @(negedge clk);
    check_eq("t5_hold_addr2", avm_address, 32'h40);
    avm_waitrequest = 1'b0;
    @(negedge clk);
    check_eq("t5_new_read", 32'(avm_read), 32'd1);
    check_eq("t5_new_addr", avm_address, 32'h100);
    expect_stream("t5", 32'h100, 4);

    // 6: reset asserted mid-burst clears outputs immediately, fetch restarts at RESET_PC
    do_reset(1);
    consume = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("t6_ir_valid", 32'(ir_valid), 32'd0);
    check_eq("t6_read", 32'(avm_read), 32'd0);
    check_eq("t6_addr", avm_address, 32'h0);
    check_eq("t6_occ", 32'(occupancy), 32'd0);
    check_eq("t6_ir", ir, 32'h0);
    check_eq("t6_ir_pc", ir_pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_restart_read", 32'(avm_read), 32'd1);
    check_eq("t6_restart_addr", avm_address, 32'h0);
    repeat (2) @(negedge clk);
    check_eq("t6_restart_valid", 32'(ir_valid), 32'd1);
    check_eq("t6_restart_pc", ir_pc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
